// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO, ALU issue register and result register with valid/ready handshake.
// Optional accumulator forwarding is enabled by defining ALU_CMD_ACC_FORWARD_EN.
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  output logic [3:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_flags,
  output logic [3:0]       res_op,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
`ifdef ALU_CMD_ACC_FORWARD_EN
  localparam int EW = 21;
`else
  localparam int EW = 20;
`endif
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             issue_valid_q, issue_valid_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [2:0]       res_flags_q, res_flags_d;
  logic [3:0]       res_op_q, res_op_d;
  logic [EW-1:0]    entry_in, head;
  logic [7:0]       head_a;
  logic             fifo_nempty, push, pop, res_take, issue_adv, res_cap;
`ifdef ALU_CMD_ACC_FORWARD_EN
  logic [7:0]       acc_q, acc_d;
  assign entry_in = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
`else
  logic             unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
  assign entry_in = {cmd_op, cmd_a, cmd_b};
`endif
  assign head        = mem_q[rd_ptr_q];
  assign fifo_nempty = count_q != '0;
  assign cmd_ready   = (count_q != CNT_W'(DEPTH)) & ~flush;
  assign push        = cmd_valid & cmd_ready;
  assign res_take    = ~res_valid_q | res_ready;
  assign issue_adv   = ~issue_valid_q | res_take;
  assign pop         = issue_adv & fifo_nempty & ~flush;
  assign res_cap     = issue_valid_q & res_take;
`ifdef ALU_CMD_ACC_FORWARD_EN
  // A forwarded operand takes the result being captured this edge, else the accumulator.
  assign head_a = head[20] ? (res_cap ? alu_result : acc_q) : head[15:8];
  assign acc_d  = res_cap ? alu_result : acc_q;
`else
  assign head_a = head[15:8];
`endif
  // Next-state for FIFO, issue register and result register.
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (push) mem_d[wr_ptr_q] = entry_in;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    issue_valid_d = flush ? 1'b0 : issue_adv ? fifo_nempty : issue_valid_q;
    alu_op_d      = pop ? head[19:16] : alu_op_q;
    alu_a_d       = pop ? head_a : alu_a_q;
    alu_b_d       = pop ? head[7:0] : alu_b_q;
    res_valid_d   = res_cap | (res_valid_q & ~res_ready);
    res_data_d    = res_cap ? alu_result : res_data_q;
    res_flags_d   = res_cap ? {alu_zero, alu_neg, alu_ovf} : res_flags_q;
    res_op_d      = res_cap ? alu_op_q : res_op_q;
  end
  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      res_op_q      <= '0;
`ifdef ALU_CMD_ACC_FORWARD_EN
      acc_q         <= '0;
`endif
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_flags_q   <= res_flags_d;
      res_op_q      <= res_op_d;
`ifdef ALU_CMD_ACC_FORWARD_EN
      acc_q         <= acc_d;
`endif
    end
  end
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_flags  = res_flags_q;
  assign res_op     = res_op_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: directed vector bench for alu_cmd_issue with a behavioural ALU_8 attached.
module tb_alu_cmd_issue;
  logic       clk = 0, rst_n, flush, cmd_valid, cmd_ready, cmd_use_acc;
  logic [3:0] cmd_op, alu_op, res_op;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, res_data;
  logic       alu_zero, alu_neg, alu_ovf, res_valid, res_ready;
  logic [2:0] res_flags;
  logic [2:0] fifo_count;
  int tests = 0, fails = 0;

  alu_cmd_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags), .res_op(res_op),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // ALU_8 stand-in: 0 A+B, 1 B-A, 2 A+1, others A&B.
  always_comb begin
    alu_result = alu_a & alu_b;
    alu_ovf    = 1'b0;
    if (alu_op == 4'd0) begin
      alu_result = alu_a + alu_b;
      alu_ovf    = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
    end else if (alu_op == 4'd1) begin
      alu_result = alu_b - alu_a;
      alu_ovf    = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_b[7]);
    end else if (alu_op == 4'd2) begin
      alu_result = alu_a + 8'd1;
      alu_ovf    = alu_a == 8'h7f;
    end
    alu_zero = alu_result == 8'd0;
    alu_neg  = alu_result[7];
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, exp_d;
    logic [2:0] exp_f;
  } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic offer(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = acc; cmd_valid = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic rdy;
    vecs[0] = '{4'd0, 8'd15,  8'd10,   8'd25,  3'b000};
    vecs[1] = '{4'd0, 8'd100, 8'd50,   8'd150, 3'b011};
    vecs[2] = '{4'd1, 8'd30,  8'd10,   8'd236, 3'b010};
    vecs[3] = '{4'd0, 8'd200, 8'd56,   8'd0,   3'b100};
    vecs[4] = '{4'd1, 8'd5,   8'd5,    8'd0,   3'b100};
    vecs[5] = '{4'd2, 8'd127, 8'd0,    8'd128, 3'b011};
    vecs[6] = '{4'd3, 8'hf0,  8'h3c,   8'h30,  3'b000};
    vecs[7] = '{4'd1, 8'd1,   8'h80,   8'd127, 3'b001};
    rst_n = 0; flush = 0; cmd_valid = 0; cmd_use_acc = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; res_ready = 1;
    #12;
    chk("reset res_valid", res_valid, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset alu_a", alu_a, 0);
    @(negedge clk) rst_n = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      offer(vecs[i].op, vecs[i].a, vecs[i].b, 0);
      chk("vec cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 0;
      chk("vec fifo_count", fifo_count, 1);
      tick();
      chk("vec alu_op", alu_op, vecs[i].op);
      chk("vec alu_a", alu_a, vecs[i].a);
      chk("vec alu_b", alu_b, vecs[i].b);
      tick();
      chk("vec res_valid", res_valid, 1);
      chk("vec res_data", res_data, vecs[i].exp_d);
      chk("vec res_flags", res_flags, vecs[i].exp_f);
      chk("vec res_op", res_op, vecs[i].op);
      tick();
      chk("vec res_drained", res_valid, 0);
    end
    offer(4'd0, 8'd100, 8'd50, 0);
    tick();
    offer(4'd1, 8'd30, 8'd10, 0);
    tick();
    cmd_valid = 0;
    tick();
    chk("b2b first data", res_data, 150);
    chk("b2b first flags", res_flags, 3'b011);
    tick();
    chk("b2b second data", res_data, 236);
    chk("b2b second flags", res_flags, 3'b010);
    chk("b2b second op", res_op, 1);
    tick();
    res_ready = 0;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      offer(4'd0, 8'(n), 8'd10, 0);
      rdy = cmd_ready;
      tick();
      if (rdy) n++;
    end
    cmd_valid = 0;
    chk("bp accepted", n, 6);
    chk("bp fifo_count", fifo_count, 4);
    chk("bp cmd_ready", cmd_ready, 0);
    chk("bp held data", res_data, 10);
    res_ready = 1;
    for (int j = 1; j < 6; j++) begin
      tick();
      chk("bp drain valid", res_valid, 1);
      chk("bp drain data", res_data, j + 10);
    end
    chk("bp cmd_ready after", cmd_ready, 1);
    tick();
    chk("bp empty", res_valid, 0);
    res_ready = 0;
    for (int i = 0; i < 5; i++) begin
      offer(4'd0, 8'(40 + i), 8'd1, 0);
      tick();
    end
    cmd_valid = 0;
    chk("flush pre count", fifo_count, 3);
    flush = 1;
    offer(4'd0, 8'd9, 8'd9, 0);
    #1;
    chk("flush cmd_ready", cmd_ready, 0);
    tick();
    flush = 0;
    cmd_valid = 0;
    chk("flush count", fifo_count, 0);
    chk("flush res kept", res_valid, 1);
    chk("flush res data", res_data, 41);
    res_ready = 1;
    tick();
    chk("flush res taken", res_valid, 0);
    tick();
    tick();
    chk("flush no more", res_valid, 0);
    res_ready = 0;
    for (int i = 0; i < 4; i++) begin
      offer(4'd3, 8'(60 + i), 8'hff, 0);
      tick();
    end
    cmd_valid = 0;
    chk("rst pre valid", res_valid, 1);
    chk("rst pre alu_op", alu_op, 3);
    rst_n = 0;
    #1;
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
    chk("rst res_op", res_op, 0);
    chk("rst alu_op", alu_op, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    @(negedge clk) rst_n = 1;
    res_ready = 1;
    tick();
    tick();
    tick();
    chk("rst no result", res_valid, 0);
`ifdef ALU_CMD_ACC_FORWARD_EN
    offer(4'd0, 8'd15, 8'd10, 0);
    tick();
    offer(4'd0, 8'd99, 8'd5, 1);
    tick();
    offer(4'd2, 8'd77, 8'd0, 1);
    tick();
    cmd_valid = 0;
    cmd_use_acc = 0;
    chk("acc first", res_data, 25);
    tick();
    chk("acc second", res_data, 30);
    tick();
    chk("acc third", res_data, 31);
    chk("acc third op", res_op, 2);
`else
    offer(4'd0, 8'd3, 8'd4, 1);
    tick();
    cmd_valid = 0;
    cmd_use_acc = 0;
    tick();
    chk("noacc alu_a", alu_a, 3);
    tick();
    chk("noacc data", res_data, 7);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
Command-issue and result-capture stage wrapped around the 8-bit ALU_8 datapath.
- Buffers {op, A, B} commands in a small FIFO.
- Drives the ALU's A/B/AluOp inputs from an issue register.
- Registers the ALU's Result/Zero/Negative/Overflow outputs into a result register with a valid/ready handshake.
- The ALU stays purely combinational; this block supplies all sequencing, buffering and backpressure.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO and issue stage
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready at the edge
cmd_op  in  4  ALU opcode
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_use_acc  in  1  replace A with accumulator (ACC_FORWARD_EN only; otherwise ignored)
alu_op  out  4  to ALU AluOp
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_result  in  8  from ALU Result
alu_zero  in  1  from ALU Zero
alu_neg  in  1  from ALU Negative
alu_ovf  in  1  from ALU Overflow
res_valid  out  1  result register holds a result
res_ready  in  1  consumer takes result
res_data  out  8  captured Result
res_flags  out  3  captured {Zero, Negative, Overflow}
res_op  out  4  opcode that produced res_data
fifo_count  out  CNT_W  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, async): all pointers, fifo_count, issue_valid, res_valid, alu_op/alu_a/alu_b, res_data/res_flags/res_op and accumulator go to 0. cmd_ready goes to 1.
- cmd_ready = (fifo_count != DEPTH) & ~flush. It is a registered-state function only, with no combinational path from res_ready or cmd_valid.
- Pipeline: FIFO -> issue register (drives ALU) -> result register.
- The result register loads when res_empty_or_taken = ~res_valid | res_ready.
- The issue register advances when ~issue_valid | res_empty_or_taken.
- When it advances, it loads the FIFO head if the FIFO is non-empty; otherwise issue_valid goes to 0.
- The result register captures alu_result/flags/alu_op when issue_valid & res_empty_or_taken. Otherwise it holds, or clears res_valid on res_ready.
- Latency: a command accepted at edge k, with an empty pipeline, is on alu_* after edge k+1 and on res_* with res_valid=1 after edge k+2. There is no FIFO bypass.
- Throughput: one command per clock when res_ready is held 1.
- Total capacity with res_ready=0 is DEPTH+2 commands: FIFO, issue register and result register.
- Simultaneous push and pop: fifo_count is unchanged. When full, pop plus push is still blocked because cmd_ready is 0 that cycle.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO order; results emerge in command order.
- flush (sync): clears FIFO pointers/count and issue_valid. The result register and accumulator are retained. Commands offered during flush are not accepted.
- Reset mid-operation discards all in-flight commands with no result produced.
- alu_* hold their last value when issue_valid=0.
- res_* hold while res_valid=1 and res_ready=0.

Optional Feature:
Macro: ALU_CMD_ACC_FORWARD_EN
- Defined:
  - An 8-bit accumulator loads res_data's source (alu_result) whenever the result register captures.
  - When a command with cmd_use_acc=1 enters the issue register, alu_a takes the newest result. If the result register captures in that same edge, it takes alu_result directly (bypass); otherwise it takes the accumulator.
  - cmd_use_acc is stored per FIFO entry.
- Undefined: cmd_use_acc is ignored, no accumulator exists, and alu_a always takes the stored cmd_a.

Test Plan:
1. Single command: push op=0000, A=15, B=10, res_ready=1 -> after 2 edges res_valid=1, res_data=25, res_flags=000, res_op=0000.
2. Overflow and order: push add 100+50, then op=0001 A=30 B=10 back-to-back -> res_data=150 flags=011, then 236 flags=010 on consecutive cycles.
3. Backpressure: res_ready=0, DEPTH=4; offer 7 commands -> 6 accepted, cmd_ready=0 with fifo_count=4. Raise res_ready -> all 6 results in order, one per cycle, then cmd_ready=1.
4. Flush: 3 commands queued, res_ready=0, pulse flush -> fifo_count=0, the held result remains valid, and only that one result appears after res_ready=1.
5. Reset mid-stream: assert rst_n=0 with 4 queued -> all outputs 0 immediately, cmd_ready=1, no result after release.
6. ALU_CMD_ACC_FORWARD_EN: push add 15+10, then use_acc add B=5, then use_acc op=0010 back-to-back -> results 25, 30, 31.
